font_rom_arbiter: RTL and testbench

//  Shares one combinational font8x16_rom between NUM_REQ glyph renderers (x8 title, x4 labels, ...).

---
 rtl/font_arb_pkg.sv | 18 +
 rtl/font8x16_rom.sv | 13 +
 rtl/font_arb_rr_pick.sv | 29 ++
 rtl/font_rom_arbiter.sv | 111 +++++++++++
 tb/tb_font_rom_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/font_arb_pkg.sv
// Shared types and constants for the font ROM arbiter and its pick logic.
package font_arb_pkg;

    localparam int CH_W     = 8;
    localparam int ROW_W    = 4;
    localparam int BITS_W   = 8;
    localparam int ARB_LAT  = 2;
    // Tag field sized for the largest supported requester count (8).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                v;
        logic [ID_MAX_W-1:0] id;
        logic [CH_W-1:0]     ch;
        logic [ROW_W-1:0]    row;
    } font_lookup_t;

endpackage

// File: rtl/font8x16_rom.sv
// Combinational 8x16 font row lookup. Procedural glyph pattern with blank
// top/bottom rows, standing in for the full character table.
module font8x16_rom
    import font_arb_pkg::*;
(
    input  logic [CH_W-1:0]   ch,
    input  logic [ROW_W-1:0]  row,
    output logic [BITS_W-1:0] bits
);

    assign bits = (row == '0 || row == '1) ? '0 : (ch ^ {row, ~row});

endmodule

// File: rtl/font_arb_rr_pick.sv
// Rotate-and-priority-encode: first set bit of req at or after ptr, wrapping.
module font_arb_rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = W'(c);
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one font8x16_rom among NUM_REQ requesters,
// 2-cycle response latency. Define FONT_ARB_FIXED_PRIO_EN to give requester 0 absolute priority.
module font_rom_arbiter
    import font_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CH_W-1:0]  req_ch,
    input  logic [NUM_REQ*ROW_W-1:0] req_row,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [BITS_W-1:0]        rsp_bits,
    output logic                     busy
);

    logic [NUM_REQ-1:0][CH_W-1:0]  ch_arr;
    logic [NUM_REQ-1:0][ROW_W-1:0] row_arr;
    logic [ID_W-1:0]               ptr;
    logic [NUM_REQ-1:0]            rr_req, rr_gnt, gnt;
    logic [ID_W-1:0]               rr_idx, gnt_idx;
    logic                          rr_any, gnt_any, ptr_move;
    font_lookup_t                  s1;
    logic [BITS_W-1:0]             rom_bits;

    assign ch_arr  = req_ch;
    assign row_arr = req_row;

    font_arb_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (rr_req),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

`ifdef FONT_ARB_FIXED_PRIO_EN
    // Requester 0 bypasses the rotation and never disturbs ptr.
    assign rr_req = {req_valid[NUM_REQ-1:1], 1'b0};

    always_comb begin
        gnt      = rr_gnt;
        gnt_idx  = rr_idx;
        gnt_any  = rr_any;
        ptr_move = rr_any;
        if (req_valid[0]) begin
            gnt      = NUM_REQ'(1);
            gnt_idx  = '0;
            gnt_any  = 1'b1;
            ptr_move = 1'b0;
        end
    end
`else
    assign rr_req   = req_valid;
    assign gnt      = rr_gnt;
    assign gnt_idx  = rr_idx;
    assign gnt_any  = rr_any;
    assign ptr_move = rr_any;
`endif

    assign req_ready = reset ? '0 : gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_any && ptr_move) begin
            ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.v <= gnt_any;
            if (gnt_any) begin
                s1.id  <= ID_MAX_W'(gnt_idx);
                s1.ch  <= ch_arr[gnt_idx];
                s1.row <= row_arr[gnt_idx];
            end
        end
    end

    font8x16_rom u_rom (
        .ch   (s1.ch),
        .row  (s1.row),
        .bits (rom_bits)
    );

    // Response fields only update on a live lookup so they hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_bits  <= '0;
        end else begin
            rsp_valid <= s1.v ? (NUM_REQ'(1) << s1.id) : '0;
            if (s1.v) begin
                rsp_id   <= s1.id[ID_W-1:0];
                rsp_bits <= rom_bits;
            end
        end
    end

    assign busy = s1.v | (|rsp_valid);

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: directed scenarios plus a
// scoreboard tracking every handshake to its response two cycles later.
module tb_font_rom_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_ch = '0;
    logic [N*4-1:0] req_row = '0;
    logic [N-1:0]   rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_bits;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         id;
        logic [7:0] bits;
        int         due;
    } exp_t;
    exp_t q[$];

    font_rom_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ch    (req_ch),
        .req_row   (req_row),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_bits  (rsp_bits),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph pattern: rows 0 and 15 blank, otherwise ch xor {row, 15-row}.
    function automatic logic [7:0] font_model(input logic [7:0] ch, input logic [3:0] r);
        if (r == 4'd0 || r == 4'd15) return 8'h00;
        return ch ^ {r, 4'hF - r};
    endfunction

    task automatic scoreboard();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (rsp_valid != '0) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL rsp_unexpected: rsp_valid=%b, expected no response", rsp_valid);
                    end else begin
                        e = q.pop_front();
                        if (cyc !== e.due || rsp_id !== 2'(e.id) || rsp_bits !== e.bits
                            || rsp_valid !== (4'b0001 << e.id)) begin
                            fails++;
                            $display("FAIL rsp_match: cyc=%0d id=%0d bits=%h v=%b, expected cyc=%0d id=%0d bits=%h",
                                     cyc, rsp_id, rsp_bits, rsp_valid, e.due, e.id, e.bits);
                        end
                    end
                end
                tests++;
                if ((req_ready & ~req_valid) != '0 || !$onehot0(req_ready)) begin
                    fails++;
                    $display("FAIL ready_legal: ready=%b valid=%b", req_ready, req_valid);
                end
                for (int i = 0; i < N; i++)
                    if (req_valid[i] && req_ready[i])
                        q.push_back('{i, font_model(req_ch[i*8 +: 8], req_row[i*4 +: 4]), cyc + 2});
            end
        end
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        req_valid = '0;
        reset     = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        mon_en    = 1'b0;
        req_valid = '1;
        reset     = 1'b1;
        #3;
        tests++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_id !== 2'd0
            || rsp_bits !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b rsp_v=%b id=%0d bits=%h busy=%b, expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_bits, busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b0100; req_ch[23:16] = 8'h41; req_row[11:8] = 4'd5;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0100 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: ready=%b busy=%b, expected 0100 0", req_ready, busy);
        end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
            fails++;
            $display("FAIL single_n1: busy=%b rsp_v=%b, expected 1 0000", busy, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_bits !== 8'h1B || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_n2: v=%b id=%0d bits=%h busy=%b, expected 0100 2 1b 1",
                     rsp_valid, rsp_id, rsp_bits, busy);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_bits !== 8'h1B || rsp_id !== 2'd2) begin
            fails++;
            $display("FAIL single_hold: v=%b busy=%b bits=%h id=%0d, expected 0000 0 1b 2",
                     rsp_valid, busy, rsp_bits, rsp_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_ch[i*8 +: 8]  = 8'h30 + 8'(i);
            req_row[i*4 +: 4] = 4'(i + 1);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1 req_valid = '1;
            @(negedge clk);
            tests++;
            if (req_ready !== (4'b0001 << (k % N))) begin
                fails++;
                $display("FAIL rr_order k=%0d: ready=%b, expected %b", k, req_ready, 4'b0001 << (k % N));
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pair();
        logic [3:0] vseq [5] = '{4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1011};
        logic [3:0] gexp [5] = '{4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 req_valid = vseq[k];
            @(negedge clk);
            tests++;
            if (req_ready !== gexp[k]) begin
                fails++;
                $display("FAIL pair_grant k=%0d: ready=%b, expected %b", k, req_ready, gexp[k]);
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1 req_valid = '1;
        @(posedge clk); @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1 || rsp_valid === 4'b0000) begin
            fails++;
            $display("FAIL midrst_setup: busy=%b rsp_v=%b, expected busy with a response", busy, rsp_valid);
        end
        #1;
        mon_en = 1'b0; q.delete();
        reset = 1'b1; req_valid = '0;
        #1;
        tests++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_async: rsp_v=%b busy=%b ready=%b, expected 0", rsp_valid, busy, req_ready);
        end
        @(posedge clk); #1 reset = 1'b0; mon_en = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 req_valid = '1;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_first: ready=%b, expected 0001", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

`ifdef FONT_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [3:0] vseq [7] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1110, 4'b1110, 4'b1110};
        logic [3:0] gexp [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0010};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1 req_valid = vseq[k];
            @(negedge clk);
            tests++;
            if (req_ready !== gexp[k]) begin
                fails++;
                $display("FAIL prio_grant k=%0d: ready=%b, expected %b", k, req_ready, gexp[k]);
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] pend;
        int           waitc [N];
        do_reset();
        pend = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        repeat (10000) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    req_ch[i*8 +: 8]  = 8'($urandom);
                    req_row[i*4 +: 4] = 4'($urandom);
                end
            end
            req_valid = pend;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if (req_ready[i]) begin
`ifndef FONT_ARB_FIXED_PRIO_EN
                        tests++;
                        if (waitc[i] > N - 1) begin
                            fails++;
                            $display("FAIL rand_wait req=%0d: waited %0d, expected <= %0d", i, waitc[i], N - 1);
                        end
`endif
                        waitc[i] = 0;
                        pend[i]  = 1'b0;
                    end else begin
                        waitc[i]++;
                    end
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        fork
            scoreboard();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_pair();
        test_reset_mid();
`ifdef FONT_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
